// File: rtl/xcvr651_sequencer.sv
// Host-side sequencer that turns single-cycle write/read requests into timed '651 transceiver strobes.
// Registered outputs; one request in flight at a time; the response is held until rsp_ready.
module xcvr651_sequencer #(
  parameter int DW         = 8,
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 2,
  parameter int HOLD_CYC   = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_dir,
  input  logic [DW-1:0] req_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_dir,
  output logic [DW-1:0] rsp_data,
  output logic          cpab,
  output logic          cpba,
  output logic          sab,
  output logic          sba,
  output logic [DW-1:0] a_drv,
  output logic          a_oe,
  input  logic [DW-1:0] a_in
);

  localparam int S_CYC  = (SETUP_CYC  < 1) ? 1 : SETUP_CYC;
  localparam int P_CYC  = (PULSE_CYC  < 1) ? 1 : PULSE_CYC;
  localparam int H_CYC  = (HOLD_CYC   < 1) ? 1 : HOLD_CYC;
  localparam int T_CYC  = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  localparam int MAX_A  = (S_CYC > P_CYC) ? S_CYC : P_CYC;
  localparam int MAX_B  = (H_CYC > T_CYC) ? H_CYC : T_CYC;
  localparam int MAXC   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW     = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_CLK, W_HOLD, R_CLK, R_SETTLE, RESP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, reload_val;
  logic          last;

  assign last = (cnt == CW'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req_valid && req_ready) state_nxt = req_dir ? R_CLK : W_SETUP;
      W_SETUP:  if (last) state_nxt = W_CLK;
      W_CLK:    if (last) state_nxt = W_HOLD;
      W_HOLD:   if (last) state_nxt = RESP;
      R_CLK:    if (last) state_nxt = R_SETTLE;
      R_SETTLE: if (last) state_nxt = RESP;
      RESP:     if (rsp_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Each state owns a fresh dwell count on entry; the count never wraps.
  always_comb begin
    reload_val = '0;
    case (state_nxt)
      W_SETUP:  reload_val = CW'(S_CYC);
      W_CLK:    reload_val = CW'(P_CYC);
      W_HOLD:   reload_val = CW'(H_CYC);
      R_CLK:    reload_val = CW'(P_CYC);
      R_SETTLE: reload_val = CW'(T_CYC);
      default:  reload_val = '0;
    endcase
    cnt_nxt = cnt;
    if (state_nxt != state) cnt_nxt = reload_val;
    else if (cnt > CW'(1))  cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are decoded from the next state so every strobe comes straight off a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dir   <= 1'b0;
      rsp_data  <= '0;
      cpab      <= 1'b0;
      cpba      <= 1'b0;
      sab       <= 1'b0;
      sba       <= 1'b0;
      a_drv     <= '0;
      a_oe      <= 1'b0;
    end else begin
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
      cpab      <= (state_nxt == W_CLK);
      cpba      <= (state_nxt == R_CLK);
      a_oe      <= (state_nxt == W_SETUP) || (state_nxt == W_CLK) || (state_nxt == W_HOLD);
      case (state_nxt)
        IDLE, W_SETUP, R_CLK: begin
          sab <= 1'b0;
          sba <= 1'b0;
        end
        W_HOLD:   sab <= 1'b1;
        R_SETTLE: sba <= 1'b1;
        default: ;
      endcase
      if (state == IDLE && state_nxt == W_SETUP) a_drv <= req_data;
      if (state == W_HOLD && state_nxt == RESP) begin
        rsp_data <= '0;
        rsp_dir  <= 1'b0;
      end
      if (state == R_SETTLE && state_nxt == RESP) begin
        rsp_data <= a_in;
        rsp_dir  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xcvr651_sequencer.sv
// Directed bench for xcvr651_sequencer: default build with a '651 register model, plus a minimum-timing build.
module tb_xcvr651_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         checks = 0;
  int         passes = 0;

  always #5 clk = ~clk;

  // Default-parameter instance
  logic       req_valid = 0, req_dir = 0, rsp_ready = 0;
  logic [7:0] req_data = 0;
  logic       req_ready, rsp_valid, rsp_dir, cpab, cpba, sab, sba, a_oe;
  logic [7:0] rsp_data, a_drv, a_in;

  // Minimum-timing instance (SETUP_CYC=0 -> 1, PULSE_CYC=1)
  logic       req_valid2 = 0, req_dir2 = 0, rsp_ready2 = 0;
  logic [7:0] req_data2 = 0;
  logic       req_ready2, rsp_valid2, rsp_dir2, cpab2, cpba2, sab2, sba2, a_oe2;
  logic [7:0] rsp_data2, a_drv2, a_in2;

  // '651 model: A->B register on cpab, B->A register on cpba, optional B loopback
  logic [7:0] reg_ab = 0, reg_ba = 0, b_ext = 0, b_i;
  logic       loop_b = 0;
  assign b_i  = loop_b ? reg_ab : b_ext;
  assign a_in = sba ? reg_ba : (a_oe ? a_drv : 8'h00);
  always @(posedge cpab) reg_ab <= a_drv;
  always @(posedge cpba) reg_ba <= b_i;
  assign a_in2 = sba2 ? 8'h5A : 8'h00;

  xcvr651_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dir(rsp_dir),
    .rsp_data(rsp_data), .cpab(cpab), .cpba(cpba), .sab(sab), .sba(sba), .a_drv(a_drv),
    .a_oe(a_oe), .a_in(a_in)
  );

  xcvr651_sequencer #(.SETUP_CYC(0), .PULSE_CYC(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2), .req_dir(req_dir2),
    .req_data(req_data2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_dir(rsp_dir2),
    .rsp_data(rsp_data2), .cpab(cpab2), .cpba(cpba2), .sab(sab2), .sba(sba2), .a_drv(a_drv2),
    .a_oe(a_oe2), .a_in(a_in2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Protocol invariants on both builds, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert (!(a_oe && sba) && !(cpab && cpba) && !(a_oe2 && sba2) && !(cpab2 && cpba2)) passes++;
      else $error("FAIL overlap observed=%b%b%b%b expected=no overlap", a_oe & sba, cpab & cpba, a_oe2 & sba2, cpab2 & cpba2);
    end
  end

  // One complete transfer on the default build; checks busy window and latency.
  task automatic xfer(input logic dir, input logic [7:0] d, input int lat, output logic [7:0] rd);
    req_valid = 1; req_dir = dir; req_data = d;
    step(1);
    req_valid = 0;
    for (int k = 1; k <= lat; k++) begin
      chk("xfer_busy_ready", req_ready, 0);
      chk("xfer_busy_valid", rsp_valid, 0);
      step(1);
    end
    chk("xfer_rsp_valid", rsp_valid, 1);
    chk("xfer_rsp_dir", rsp_dir, dir);
    rd = rsp_data;
    rsp_ready = 1;
    step(1);
    rsp_ready = 0;
    chk("xfer_idle_ready", req_ready, 1);
  endtask

  logic [7:0] rd;

  initial begin
    // Reset state
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_strobes", {cpab, cpba, sab, sba, a_oe}, 5'b0);
    #9 rst_n = 1;
    step(1);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_ready2", req_ready2, 1);

    // Write 0xA5, default timing
    req_valid = 1; req_dir = 0; req_data = 8'hA5;
    step(1);
    req_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) step(1);
      chk("wr_a_oe", a_oe, (k <= 5));
      chk("wr_cpab", cpab, (k == 3 || k == 4));
      chk("wr_sab", sab, (k >= 5));
      chk("wr_rsp_valid", rsp_valid, (k == 6));
      chk("wr_req_ready", req_ready, 0);
      if (k <= 5) chk("wr_a_drv", a_drv, 8'hA5);
    end
    chk("wr_rsp_data", rsp_data, 8'h00);
    chk("wr_rsp_dir", rsp_dir, 0);
    chk("wr_reg_ab", reg_ab, 8'hA5);
    rsp_ready = 1;
    step(1);
    rsp_ready = 0;
    chk("wr_done_valid", rsp_valid, 0);
    chk("wr_done_ready", req_ready, 1);
    chk("wr_done_sab", sab, 0);

    // Asynchronous reset in the middle of W_CLK
    req_valid = 1; req_dir = 0; req_data = 8'h77;
    step(1);
    req_valid = 0;
    step(2);
    chk("mid_cpab_high", cpab, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_cpab", cpab, 0);
    chk("arst_a_oe", a_oe, 0);
    chk("arst_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    step(1);
    chk("arst_rel_ready", req_ready, 1);
    chk("arst_rel_valid", rsp_valid, 0);
    step(2);
    chk("arst_no_rsp", rsp_valid, 0);

    // Read with B input 0x3C, then a 10-cycle response stall
    b_ext = 8'h3C;
    req_valid = 1; req_dir = 1;
    step(1);
    req_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) step(1);
      chk("rd_cpba", cpba, (k <= 2));
      chk("rd_sba", sba, (k >= 3));
      chk("rd_a_oe", a_oe, 0);
      chk("rd_rsp_valid", rsp_valid, (k == 5));
    end
    chk("rd_rsp_data", rsp_data, 8'h3C);
    chk("rd_rsp_dir", rsp_dir, 1);
    req_valid = 1; req_dir = 0; req_data = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, 8'h3C);
      chk("stall_dir", rsp_dir, 1);
      chk("stall_ready", req_ready, 0);
      chk("stall_a_oe", a_oe, 0);
    end
    req_valid = 0; rsp_ready = 1;
    step(1);
    rsp_ready = 0;
    chk("stall_rel_valid", rsp_valid, 0);
    chk("stall_rel_ready", req_ready, 1);
    chk("stall_rel_sba", sba, 0);
    step(1);
    chk("stall_no_start", {a_oe, cpab, cpba}, 3'b000);

    // Back-to-back write 0x11 then looped-back read
    loop_b = 1;
    xfer(0, 8'h11, 5, rd);
    chk("b2b_wr_data", rd, 8'h00);
    xfer(1, 8'h00, 4, rd);
    chk("b2b_rd_data", rd, 8'h11);

    // Minimum-timing build: write latency 3, read latency 3
    req_valid2 = 1; req_dir2 = 0; req_data2 = 8'h42;
    step(1);
    req_valid2 = 0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) step(1);
      chk("min_wr_a_oe", a_oe2, (k <= 3));
      chk("min_wr_cpab", cpab2, (k == 2));
      chk("min_wr_sab", sab2, (k >= 3));
      chk("min_wr_valid", rsp_valid2, (k == 4));
    end
    rsp_ready2 = 1;
    step(1);
    rsp_ready2 = 0;
    chk("min_wr_idle", req_ready2, 1);
    req_valid2 = 1; req_dir2 = 1;
    step(1);
    req_valid2 = 0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) step(1);
      chk("min_rd_cpba", cpba2, (k == 1));
      chk("min_rd_sba", sba2, (k >= 2));
      chk("min_rd_valid", rsp_valid2, (k == 4));
    end
    chk("min_rd_data", rsp_data2, 8'h5A);
    chk("min_rd_dir", rsp_dir2, 1);
    rsp_ready2 = 1;
    step(1);
    rsp_ready2 = 0;
    chk("min_rd_idle", req_ready2, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
